// File: rtl/and_gate_bist_ctrl.sv
// BIST sequencer for an N-input AND gate: walks every input vector, samples y after a settle window.
// Optional macro BIST_FAIL_CAPTURE_EN adds fail_valid/fail_vec/fail_y first-mismatch capture ports.
module and_gate_bist_ctrl #(
  parameter int NUM_INPUTS    = 2,
  parameter int SETTLE_CYCLES = 10,
  parameter int CNT_W         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [NUM_INPUTS-1:0] vec,
  input  logic                  y,
  output logic                  busy,
  output logic                  done,
  output logic                  pass
`ifdef BIST_FAIL_CAPTURE_EN
  ,
  output logic                  fail_valid,
  output logic [NUM_INPUTS-1:0] fail_vec,
  output logic                  fail_y
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [NUM_INPUTS-1:0] VEC_ONES = '1;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_INPUTS-1:0]   vec_q, vec_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    pass_r_q, pass_r_d;
  logic                    fail_valid_q, fail_valid_d;
  logic [NUM_INPUTS-1:0]   fail_vec_q, fail_vec_d;
  logic                    fail_y_q, fail_y_d;
  logic                    mismatch;

  assign mismatch = (y != (&vec_q));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    vec_d        = vec_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    pass_r_d     = pass_r_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    fail_y_d     = fail_y_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SETTLE;
          vec_d        = '0;
          cnt_d        = '0;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          pass_r_d     = 1'b1;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          fail_y_d     = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) state_d = CHECK;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      CHECK: begin
        if (mismatch) begin
          pass_r_d = 1'b0;
          // Only the first mismatch of a run is kept.
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
            fail_y_d     = y;
          end
        end
        if (vec_q == VEC_ONES) begin
          state_d = DONE;
          vec_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = pass_r_q & ~mismatch;
        end else begin
          state_d = SETTLE;
          vec_d   = vec_q + 1'b1;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      vec_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      pass_r_q     <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_y_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vec_q        <= vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      pass_r_q     <= pass_r_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      fail_y_q     <= fail_y_d;
    end
  end

  assign vec  = vec_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;

`ifdef BIST_FAIL_CAPTURE_EN
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign fail_y     = fail_y_q;
`else
  // Capture state is still tracked; the ports are simply absent in this build.
  logic unused_capture;
  assign unused_capture = ^{fail_valid_q, fail_vec_q, fail_y_q};
`endif

endmodule

// File: tb/tb_and_gate_bist_ctrl.sv
// Directed bench for and_gate_bist_ctrl: default 2-input instance plus a 3-input, 1-cycle-settle instance.
module tb_and_gate_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [1:0] vec_a;
  logic [2:0] vec_b;
  logic       y_a, y_b;
  logic       busy_a, done_a, pass_a;
  logic       busy_b, done_b, pass_b;
  int         mode_a;
  int         n_chk  = 0;
  int         n_fail = 0;
`ifdef BIST_FAIL_CAPTURE_EN
  logic       fv_a, fy_a, fv_b, fy_b;
  logic [1:0] fvec_a;
  logic [2:0] fvec_b;
`endif

  always #5 clk = ~clk;

  // Gate models: 0 = good AND, 1 = y stuck-at-0, 2 = y stuck-at-1.
  assign y_a = (mode_a == 1) ? 1'b0 : (mode_a == 2) ? 1'b1 : (&vec_a);
  assign y_b = &vec_b;

  and_gate_bist_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start_a), .vec(vec_a), .y(y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a)
`ifdef BIST_FAIL_CAPTURE_EN
    , .fail_valid(fv_a), .fail_vec(fvec_a), .fail_y(fy_a)
`endif
  );

  and_gate_bist_ctrl #(.NUM_INPUTS(3), .SETTLE_CYCLES(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .vec(vec_b), .y(y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b)
`ifdef BIST_FAIL_CAPTURE_EN
    , .fail_valid(fv_b), .fail_vec(fvec_b), .fail_y(fy_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input string tag, input bit exp_pass, input bit hold_start);
    int pulses;
    int dedge;
    pulses = 0;
    dedge  = -1;
    @(negedge clk);
    start_a = 1'b1;
    tick();
    if (!hold_start) start_a = 1'b0;
    chk({tag, "_busy_e0"}, busy_a, 1);
    chk({tag, "_vec_e0"}, vec_a, 0);
    for (int e = 1; e <= 47; e++) begin
      tick();
      if (done_a) begin
        pulses++;
        if (dedge < 0) dedge = e;
      end
      if (e == 10) chk({tag, "_vec_e10"}, vec_a, 0);
      if (e == 11) chk({tag, "_vec_e11"}, vec_a, 1);
      if (e == 22) chk({tag, "_vec_e22"}, vec_a, 2);
      if (e == 33) chk({tag, "_vec_e33"}, vec_a, 3);
      if (e == 43) chk({tag, "_busy_e43"}, busy_a, 1);
      if (e == 44) begin
        chk({tag, "_pass_e44"}, pass_a, 32'(exp_pass));
        chk({tag, "_busy_e44"}, busy_a, 0);
        chk({tag, "_vec_e44"}, vec_a, 0);
      end
      if (e == 45) chk({tag, "_done_e45"}, done_a, 0);
      if (e == 47 && hold_start) chk({tag, "_restart_busy"}, busy_a, 1);
    end
    chk({tag, "_done_edge"}, 32'(dedge), 44);
    chk({tag, "_done_pulses"}, 32'(pulses), 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    int dedge;
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    mode_a  = 0;
    #1;
    chk("rst_vec", vec_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    run_a("good", 1'b1, 1'b0);

    mode_a = 1;
    run_a("sa0", 1'b0, 1'b0);
`ifdef BIST_FAIL_CAPTURE_EN
    chk("sa0_fail_valid", fv_a, 1);
    chk("sa0_fail_vec", fvec_a, 3);
    chk("sa0_fail_y", fy_a, 0);
`endif

    mode_a = 2;
    run_a("sa1", 1'b0, 1'b0);
`ifdef BIST_FAIL_CAPTURE_EN
    chk("sa1_fail_valid", fv_a, 1);
    chk("sa1_fail_vec", fvec_a, 0);
    chk("sa1_fail_y", fy_a, 1);
`endif

    mode_a = 0;
    run_a("hold", 1'b1, 1'b1);
    start_a = 1'b0;
    pulse_reset();

    // Abort a run with reset right after edge 20.
    @(negedge clk);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (20) tick();
    chk("abort_busy_before", busy_a, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy_a, 0);
    chk("abort_vec", vec_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_pass", pass_a, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int e = 0; e < 50; e++) begin
      tick();
      if (done_a) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 0);
    run_a("after_abort", 1'b1, 1'b0);

    // 3-input instance, SETTLE_CYCLES=1: 8 vectors of 2 cycles.
    pulses = 0;
    dedge  = -1;
    @(negedge clk);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("n3_vec_e0", vec_b, 0);
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (done_b) begin
        pulses++;
        if (dedge < 0) dedge = e;
      end
      if (e == 2)  chk("n3_vec_e2", vec_b, 1);
      if (e == 14) chk("n3_vec_e14", vec_b, 7);
      if (e == 16) begin
        chk("n3_pass", pass_b, 1);
        chk("n3_busy_e16", busy_b, 0);
      end
    end
    chk("n3_done_edge", 32'(dedge), 16);
    chk("n3_done_pulses", 32'(pulses), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
